// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF-stage, MEM-stage and unified-memory signals around mem_port_arbiter.
// slave = arbiter view; master = pipeline/memory (environment) view.
interface mem_port_arbiter_if;
  logic        IFReq;
  logic [31:0] IFAddr;
  logic [31:0] IFRData;
  logic        IFDone;
  logic        IFStall;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] MemAddrM;
  logic [31:0] MemWDataM;
  logic [31:0] MemRDataM;
  logic        MemDone;
  logic        MemStall;
  logic        MemEn;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;

  modport slave (
    input  IFReq, IFAddr, MemReadM, MemWriteM, MemAddrM, MemWDataM, MemRData,
    output IFRData, IFDone, IFStall, MemRDataM, MemDone, MemStall,
           MemEn, MemWe, MemAddr, MemWData
  );

  modport master (
    output IFReq, IFAddr, MemReadM, MemWriteM, MemAddrM, MemWDataM, MemRData,
    input  IFRData, IFDone, IFStall, MemRDataM, MemDone, MemStall,
           MemEn, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IF fetches and MEM loads/stores (MEM has priority).
// Optional macro ARB_STARVE_GUARD_EN adds a consecutive-MEM-grant limit so IF cannot starve.
module mem_port_arbiter #(
`ifdef ARB_STARVE_GUARD_EN
  parameter int unsigned MAX_MEM_GRANTS = 4,
`endif
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                mem_req;
  logic                grant_mem;
  logic                grant_if;
  logic                done_if;
  logic                done_mem;
  logic [DATA_W-1:0]   rdata_sel;

  assign mem_req = bus.MemReadM | bus.MemWriteM;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                starved;

  // After MAX_MEM_GRANTS back-to-back MEM wins with IF waiting, IF takes the next slot.
  assign starved   = bus.IFReq && (starve_q >= CNT_W'(MAX_MEM_GRANTS));
  assign grant_mem = mem_req && !starved;

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.IFReq || grant_if) begin
        starve_d = '0;
      end else if (grant_mem && (starve_q != '1)) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign grant_mem = mem_req;
`endif

  assign grant_if = bus.IFReq && !grant_mem;

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state: the strobe is set on grant so MemEn is high exactly during ISSUE
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    count_d     = count_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (grant_mem) begin
          owner_d     = OWN_MEM;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.MemWriteM;
          mem_addr_d  = bus.MemAddrM;
          mem_wdata_d = bus.MemWDataM;
          state_d     = ISSUE;
        end else if (grant_if) begin
          owner_d    = OWN_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.IFAddr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = DONE;
        end else begin
          count_d = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion: a withdrawn request suppresses its Done and drops the data
  always_comb begin
    done_if   = 1'b0;
    done_mem  = 1'b0;
    rdata_sel = mem_we_q ? '0 : bus.MemRData;
    if (state_q == DONE) begin
      done_if  = (owner_q == OWN_IF)  && bus.IFReq;
      done_mem = (owner_q == OWN_MEM) && mem_req;
    end
  end

  assign bus.IFDone    = done_if;
  assign bus.MemDone   = done_mem;
  assign bus.IFRData   = done_if  ? rdata_sel : '0;
  assign bus.MemRDataM = done_mem ? rdata_sel : '0;
  assign bus.IFStall   = bus.IFReq & ~done_if;
  assign bus.MemStall  = mem_req & ~done_mem;
  assign bus.MemEn     = mem_en_q;
  assign bus.MemWe     = mem_we_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemWData  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: read data appears LAT cycles after the MemEn cycle
  logic [31:0] mem  [0:63];
  logic [31:0] pipe [0:LAT-1];

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h2008_0005;
      mem[2] <= 32'h1111_2222;
    end else if (bus.MemEn && bus.MemWe) begin
      mem[bus.MemAddr[7:2]] <= bus.MemWData;
    end
    pipe[0] <= (bus.MemEn && !bus.MemWe) ? mem[bus.MemAddr[7:2]] : 32'hBAD0_0000;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.MemRData = pipe[LAT-1];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic adv();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset         = 1'b1;
    bus.IFReq     = 1'b0;
    bus.IFAddr    = 32'h0;
    bus.MemReadM  = 1'b0;
    bus.MemWriteM = 1'b0;
    bus.MemAddrM  = 32'h0;
    bus.MemWDataM = 32'h0;
    #100;
    if ({bus.MemEn, bus.MemWe, bus.IFDone, bus.MemDone} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus.MemEn, bus.MemWe, bus.IFDone, bus.MemDone});
    end
    n_cmp++;
    if ({bus.MemAddr, bus.MemWData} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_bus: got %h %h want 0 0", bus.MemAddr, bus.MemWData);
    end
    n_cmp++;
    if ({bus.IFRData, bus.MemRDataM} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h %h want 0 0", bus.IFRData, bus.MemRDataM);
    end
    n_cmp++;
    #150;
    Reset = 1'b0;
    adv();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if ({bus.MemEn, bus.IFStall, bus.MemStall} !== 3'b000) begin
        n_err++;
        $display("FAIL idle c%0d: got en/ifst/memst %b want 000", c,
                 {bus.MemEn, bus.IFStall, bus.MemStall});
      end
      n_cmp++;
      adv();
    end
  endtask

  task automatic test_if_read();
    bus.IFReq  = 1'b1;
    bus.IFAddr = 32'h0000_0004;
    for (int c = 0; c < 5; c++) begin
      logic        e_en, e_done, e_stall;
      logic [31:0] e_rd;
      if (c == 4) bus.IFReq = 1'b0;
      e_en    = (c == 1);
      e_done  = (c == 3);
      e_stall = (c < 3);
      e_rd    = (c == 3) ? 32'h2008_0005 : 32'h0;
      @(negedge Clk);
      if (bus.MemEn !== e_en) begin
        n_err++;
        $display("FAIL if_read MemEn c%0d: got %b want %b", c, bus.MemEn, e_en);
      end
      n_cmp++;
      if (bus.IFDone !== e_done) begin
        n_err++;
        $display("FAIL if_read IFDone c%0d: got %b want %b", c, bus.IFDone, e_done);
      end
      n_cmp++;
      if (bus.IFStall !== e_stall) begin
        n_err++;
        $display("FAIL if_read IFStall c%0d: got %b want %b", c, bus.IFStall, e_stall);
      end
      n_cmp++;
      if (bus.IFRData !== e_rd) begin
        n_err++;
        $display("FAIL if_read IFRData c%0d: got %h want %h", c, bus.IFRData, e_rd);
      end
      n_cmp++;
      if (c == 1 && {bus.MemWe, bus.MemAddr} !== {1'b0, 32'h0000_0004}) begin
        n_err++;
        $display("FAIL if_read issue: got we=%b addr=%h want we=0 addr=00000004", bus.MemWe, bus.MemAddr);
      end
      if (c == 1) n_cmp++;
      adv();
    end
  endtask

  task automatic test_mem_write();
    bus.MemWriteM = 1'b1;
    bus.MemAddrM  = 32'h0000_0010;
    bus.MemWDataM = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      logic e_en, e_done, e_stall;
      if (c == 3) bus.MemWriteM = 1'b0;
      e_en    = (c == 1);
      e_done  = (c == 2);
      e_stall = (c < 2);
      @(negedge Clk);
      if (bus.MemEn !== e_en) begin
        n_err++;
        $display("FAIL wr MemEn c%0d: got %b want %b", c, bus.MemEn, e_en);
      end
      n_cmp++;
      if (bus.MemDone !== e_done) begin
        n_err++;
        $display("FAIL wr MemDone c%0d: got %b want %b", c, bus.MemDone, e_done);
      end
      n_cmp++;
      if (bus.MemStall !== e_stall) begin
        n_err++;
        $display("FAIL wr MemStall c%0d: got %b want %b", c, bus.MemStall, e_stall);
      end
      n_cmp++;
      if (bus.MemRDataM !== 32'h0) begin
        n_err++;
        $display("FAIL wr MemRDataM c%0d: got %h want 00000000", c, bus.MemRDataM);
      end
      n_cmp++;
      if (c == 1 && {bus.MemWe, bus.MemAddr, bus.MemWData} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin
        n_err++;
        $display("FAIL wr issue: got we=%b addr=%h wd=%h want 1 00000010 deadbeef",
                 bus.MemWe, bus.MemAddr, bus.MemWData);
      end
      if (c == 1) n_cmp++;
      adv();
    end
  endtask

  task automatic test_both_same_cycle();
    bus.IFReq    = 1'b1;
    bus.IFAddr   = 32'h0000_0008;
    bus.MemReadM = 1'b1;
    bus.MemAddrM = 32'h0000_0010;
    for (int c = 0; c < 9; c++) begin
      logic        e_en, e_ifd, e_md, e_ifs, e_ms;
      logic [31:0] e_addr, e_ifr, e_mr;
      if (c == 4) bus.MemReadM = 1'b0;
      if (c == 8) bus.IFReq = 1'b0;
      e_en   = (c == 1) || (c == 5);
      e_addr = (c == 1) ? 32'h10 : 32'h8;
      e_md   = (c == 3);
      e_ifd  = (c == 7);
      e_ms   = (c < 3);
      e_ifs  = (c < 7);
      e_mr   = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      e_ifr  = (c == 7) ? 32'h1111_2222 : 32'h0;
      @(negedge Clk);
      if ({bus.MemEn, bus.MemDone, bus.IFDone} !== {e_en, e_md, e_ifd}) begin
        n_err++;
        $display("FAIL both en/md/ifd c%0d: got %b want %b", c,
                 {bus.MemEn, bus.MemDone, bus.IFDone}, {e_en, e_md, e_ifd});
      end
      n_cmp++;
      if ({bus.MemStall, bus.IFStall} !== {e_ms, e_ifs}) begin
        n_err++;
        $display("FAIL both stalls c%0d: got %b want %b", c, {bus.MemStall, bus.IFStall}, {e_ms, e_ifs});
      end
      n_cmp++;
      if ({bus.MemRDataM, bus.IFRData} !== {e_mr, e_ifr}) begin
        n_err++;
        $display("FAIL both rdata c%0d: got %h %h want %h %h", c, bus.MemRDataM, bus.IFRData, e_mr, e_ifr);
      end
      n_cmp++;
      if (e_en && bus.MemAddr !== e_addr) begin
        n_err++;
        $display("FAIL both addr c%0d: got %h want %h", c, bus.MemAddr, e_addr);
      end
      if (e_en) n_cmp++;
      adv();
    end
  endtask

  task automatic test_if_withdraw();
    bus.IFReq  = 1'b1;
    bus.IFAddr = 32'h0000_0004;
    for (int c = 0; c < 9; c++) begin
      logic e_en, e_md, e_ifs, e_ms;
      logic [31:0] e_mr;
      if (c == 2) bus.IFReq = 1'b0;
      if (c == 4) begin
        bus.MemReadM = 1'b1;
        bus.MemAddrM = 32'h0000_0008;
      end
      if (c == 8) bus.MemReadM = 1'b0;
      e_en  = (c == 1) || (c == 5);
      e_md  = (c == 7);
      e_ifs = (c < 2);
      e_ms  = (c >= 4) && (c < 7);
      e_mr  = (c == 7) ? 32'h1111_2222 : 32'h0;
      @(negedge Clk);
      if ({bus.MemEn, bus.MemDone, bus.IFDone} !== {e_en, e_md, 1'b0}) begin
        n_err++;
        $display("FAIL withdraw en/md/ifd c%0d: got %b want %b", c,
                 {bus.MemEn, bus.MemDone, bus.IFDone}, {e_en, e_md, 1'b0});
      end
      n_cmp++;
      if ({bus.IFStall, bus.MemStall} !== {e_ifs, e_ms}) begin
        n_err++;
        $display("FAIL withdraw stalls c%0d: got %b want %b", c, {bus.IFStall, bus.MemStall}, {e_ifs, e_ms});
      end
      n_cmp++;
      if ({bus.IFRData, bus.MemRDataM} !== {32'h0, e_mr}) begin
        n_err++;
        $display("FAIL withdraw rdata c%0d: got %h %h want 00000000 %h", c, bus.IFRData, bus.MemRDataM, e_mr);
      end
      n_cmp++;
      adv();
    end
  endtask

  task automatic test_reset_mid();
    bus.IFReq  = 1'b1;
    bus.IFAddr = 32'h0000_0004;
    for (int c = 0; c < 8; c++) begin
      logic        e_en, e_ifd, e_ifs;
      logic [31:0] e_ifr;
      if (c == 2) Reset = 1'b1;
      if (c == 3) Reset = 1'b0;
      if (c == 7) bus.IFReq = 1'b0;
      e_en  = (c == 1) || (c == 4);
      e_ifd = (c == 6);
      e_ifs = (c < 6);
      e_ifr = (c == 6) ? 32'h2008_0005 : 32'h0;
      @(negedge Clk);
      if ({bus.MemEn, bus.IFDone, bus.IFStall} !== {e_en, e_ifd, e_ifs}) begin
        n_err++;
        $display("FAIL rst_mid en/ifd/ifs c%0d: got %b want %b", c,
                 {bus.MemEn, bus.IFDone, bus.IFStall}, {e_en, e_ifd, e_ifs});
      end
      n_cmp++;
      if (bus.IFRData !== e_ifr) begin
        n_err++;
        $display("FAIL rst_mid IFRData c%0d: got %h want %h", c, bus.IFRData, e_ifr);
      end
      n_cmp++;
      if (c == 2 && bus.MemAddr !== 32'h0) begin
        n_err++;
        $display("FAIL rst_mid addr_in_reset: got %h want 00000000", bus.MemAddr);
      end
      if (c == 2) n_cmp++;
      adv();
    end
  endtask

  task automatic test_starve();
    logic [31:0] g_addr [0:7];
    int          k;
    int          n_ifd;
    int          n_md;
    int          e_ifd;
    int          e_md;
    logic [31:0] e_addr;
    k     = 0;
    n_ifd = 0;
    n_md  = 0;
    bus.IFReq    = 1'b1;
    bus.IFAddr   = 32'h0000_0004;
    bus.MemReadM = 1'b1;
    bus.MemAddrM = 32'h0000_0010;
    for (int c = 0; c < 24; c++) begin
      @(negedge Clk);
      if (bus.MemEn) begin
        if (k < 8) g_addr[k] = bus.MemAddr;
        k++;
      end
      if (bus.IFDone) n_ifd++;
      if (bus.MemDone) n_md++;
      adv();
    end
`ifdef ARB_STARVE_GUARD_EN
    e_ifd = 1;
    e_md  = 5;
`else
    e_ifd = 0;
    e_md  = 6;
`endif
    if (k !== 6) begin
      n_err++;
      $display("FAIL starve grants: got %0d want 6", k);
    end
    n_cmp++;
    for (int j = 0; j < 6 && j < k; j++) begin
`ifdef ARB_STARVE_GUARD_EN
      e_addr = (j == 4) ? 32'h4 : 32'h10;
`else
      e_addr = 32'h10;
`endif
      if (g_addr[j] !== e_addr) begin
        n_err++;
        $display("FAIL starve grant%0d addr: got %h want %h", j, g_addr[j], e_addr);
      end
      n_cmp++;
    end
    if (n_ifd !== e_ifd || n_md !== e_md) begin
      n_err++;
      $display("FAIL starve dones: got if=%0d mem=%0d want if=%0d mem=%0d", n_ifd, n_md, e_ifd, e_md);
    end
    n_cmp++;
    bus.MemReadM = 1'b0;
    for (int c = 24; c < 29; c++) begin
      logic e_en, e_d;
      if (c == 28) bus.IFReq = 1'b0;
      e_en = (c == 25);
      e_d  = (c == 27);
      @(negedge Clk);
      if ({bus.MemEn, bus.IFDone} !== {e_en, e_d}) begin
        n_err++;
        $display("FAIL starve release c%0d: got en/ifd %b want %b", c, {bus.MemEn, bus.IFDone}, {e_en, e_d});
      end
      n_cmp++;
      if (e_en && bus.MemAddr !== 32'h4) begin
        n_err++;
        $display("FAIL starve release addr: got %h want 00000004", bus.MemAddr);
      end
      if (e_en) n_cmp++;
      adv();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_if_read();
    test_mem_write();
    test_both_same_cycle();
    test_if_withdraw();
    test_reset_mid();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
